// File: rtl/ex_mem_pkg.sv
// Shared types for the EX/MEM pipeline stage: branch kinds, condition codes
// and the packed EX/MEM payload register.
package ex_mem_pkg;

  localparam int EM_XLEN = 64;
  localparam int EM_REGW = 5;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_B    = 2'd1,
    BR_CBZ  = 2'd2,
    BR_COND = 2'd3
  } br_kind_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_HS = 4'd2,  COND_LO = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_e;

  typedef struct packed {
    logic               valid;
    logic [EM_XLEN-1:0] result;
    logic [EM_XLEN-1:0] store_data;
    logic [EM_REGW-1:0] rd;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem_to_reg;
    logic               br_taken;
    logic [EM_XLEN-1:0] br_target;
  } ex_mem_t;

endpackage

// File: rtl/ex_mem_if.sv
// EX-side inputs, hazard controls and registered MEM-side outputs of the
// EX/MEM stage. master = upstream/hazard driver, slave = the stage.
interface ex_mem_if
  import ex_mem_pkg::*;
#(
  parameter int XLEN = EM_XLEN,
  parameter int REGW = EM_REGW
) ();

  logic            ex_valid;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            alu_negative;
  logic            alu_carry;
  logic            alu_overflow;
  logic            ex_set_flags;
  logic [1:0]      ex_br_kind;
  logic            ex_cbnz;
  logic [3:0]      ex_cond;
  logic [XLEN-1:0] ex_br_target;
  logic [XLEN-1:0] ex_store_data;
  logic [REGW-1:0] ex_rd;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_reg_write;
  logic            ex_mem_to_reg;
  logic            stall;
  logic            flush;

  logic            mem_valid;
  logic [XLEN-1:0] mem_result;
  logic [XLEN-1:0] mem_store_data;
  logic [REGW-1:0] mem_rd;
  logic            mem_mem_read;
  logic            mem_mem_write;
  logic            mem_reg_write;
  logic            mem_mem_to_reg;
  logic            mem_br_taken;
  logic [XLEN-1:0] mem_br_target;
  logic [3:0]      nzcv;

  modport master (
    output ex_valid, alu_result, alu_zero, alu_negative, alu_carry, alu_overflow,
           ex_set_flags, ex_br_kind, ex_cbnz, ex_cond, ex_br_target, ex_store_data,
           ex_rd, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, stall, flush,
    input  mem_valid, mem_result, mem_store_data, mem_rd, mem_mem_read, mem_mem_write,
           mem_reg_write, mem_mem_to_reg, mem_br_taken, mem_br_target, nzcv
  );

  modport slave (
    input  ex_valid, alu_result, alu_zero, alu_negative, alu_carry, alu_overflow,
           ex_set_flags, ex_br_kind, ex_cbnz, ex_cond, ex_br_target, ex_store_data,
           ex_rd, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, stall, flush,
    output mem_valid, mem_result, mem_store_data, mem_rd, mem_mem_read, mem_mem_write,
           mem_reg_write, mem_mem_to_reg, mem_br_taken, mem_br_target, nzcv
  );

endinterface

// File: rtl/ex_mem_cond_eval.sv
// Combinational B.cond evaluator over {N,Z,C,V}; only built when the flag
// register exists (EXMEM_NZCV_EN).
`ifdef EXMEM_NZCV_EN
module cond_eval
  import ex_mem_pkg::*;
(
  input  cond_e      cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n_s, z_s, c_s, v_s;
  assign {n_s, z_s, c_s, v_s} = nzcv;

  // Condition-code truth table
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z_s;
      COND_NE: pass = ~z_s;
      COND_HS: pass = c_s;
      COND_LO: pass = ~c_s;
      COND_MI: pass = n_s;
      COND_PL: pass = ~n_s;
      COND_VS: pass = v_s;
      COND_VC: pass = ~v_s;
      COND_HI: pass = c_s & ~z_s;
      COND_LS: pass = ~c_s | z_s;
      COND_GE: pass = (n_s == v_s);
      COND_LT: pass = (n_s != v_s);
      COND_GT: pass = ~z_s & (n_s == v_s);
      COND_LE: pass = z_s | (n_s != v_s);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule
`endif

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution and the NZCV flag register.
// Optional feature: EXMEM_NZCV_EN (flag register and B.cond evaluation).
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int XLEN = EM_XLEN,
  parameter int REGW = EM_REGW
) (
  input  logic       clk,
  input  logic       rst_n,
  ex_mem_if.slave    bus
);

  ex_mem_t  ex_mem_r;
  ex_mem_t  next_s;
  br_kind_e br_kind_s;
  logic     br_raw_s;
  logic     cond_pass_s;

  assign br_kind_s = br_kind_e'(bus.ex_br_kind);

`ifdef EXMEM_NZCV_EN
  logic [3:0] nzcv_r;
  logic       flag_we_s;

  cond_eval u_cond_eval (
    .cond (cond_e'(bus.ex_cond)),
    .nzcv (nzcv_r),
    .pass (cond_pass_s)
  );

  // B.cond consumes flags rather than producing them, so it never writes NZCV
  assign flag_we_s = bus.ex_valid & bus.ex_set_flags & ~bus.stall & ~bus.flush
                   & (br_kind_s != BR_COND);

  // Architectural flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv_r <= 4'b0000;
    end else if (flag_we_s) begin
      nzcv_r <= {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
    end
  end

  assign bus.nzcv = nzcv_r;
`else
  logic unused_s;
  assign unused_s    = ^{bus.ex_cond, bus.ex_set_flags, bus.alu_negative,
                         bus.alu_carry, bus.alu_overflow};
  assign cond_pass_s = 1'b0;
  assign bus.nzcv    = 4'b0000;
`endif

  // Raw branch outcome; CBZ/CBNZ sees Rt through the ALU in pass-B mode
  always_comb begin
    br_raw_s = 1'b0;
    case (br_kind_s)
      BR_NONE: br_raw_s = 1'b0;
      BR_B:    br_raw_s = 1'b1;
      BR_CBZ:  br_raw_s = bus.alu_zero ^ bus.ex_cbnz;
      BR_COND: br_raw_s = cond_pass_s;
      default: br_raw_s = 1'b0;
    endcase
  end

  // Assemble the payload presented by the EX slot
  always_comb begin
    next_s            = '0;
    next_s.valid      = bus.ex_valid;
    next_s.result     = bus.alu_result[XLEN-1:0];
    next_s.store_data = bus.ex_store_data[XLEN-1:0];
    next_s.rd         = bus.ex_rd[REGW-1:0];
    next_s.mem_read   = bus.ex_mem_read;
    next_s.mem_write  = bus.ex_mem_write;
    next_s.reg_write  = bus.ex_reg_write;
    next_s.mem_to_reg = bus.ex_mem_to_reg;
    next_s.br_taken   = bus.ex_valid & br_raw_s;
    next_s.br_target  = bus.ex_br_target[XLEN-1:0];
  end

  // Payload register: stall holds (and masks flush), flush loads an all-zero bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_r <= '0;
    end else if (bus.stall) begin
      ex_mem_r <= ex_mem_r;
    end else if (bus.flush) begin
      ex_mem_r <= '0;
    end else begin
      ex_mem_r <= next_s;
    end
  end

  assign bus.mem_valid      = ex_mem_r.valid;
  assign bus.mem_result     = ex_mem_r.result;
  assign bus.mem_store_data = ex_mem_r.store_data;
  assign bus.mem_rd         = ex_mem_r.rd;
  assign bus.mem_mem_read   = ex_mem_r.mem_read;
  assign bus.mem_mem_write  = ex_mem_r.mem_write;
  assign bus.mem_reg_write  = ex_mem_r.reg_write;
  assign bus.mem_mem_to_reg = ex_mem_r.mem_to_reg;
  assign bus.mem_br_taken   = ex_mem_r.br_taken;
  assign bus.mem_br_target  = ex_mem_r.br_target;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage; expectations follow the EXMEM_NZCV_EN build setting.
module tb_ex_mem_stage;
  import ex_mem_pkg::*;

  typedef struct packed {
    ex_mem_t    p;
    logic [3:0] nzcv;
  } obs_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;
  obs_t model_r;
  obs_t sb_q[$];

  ex_mem_if #(.XLEN(64), .REGW(5)) bus ();

  ex_mem_stage #(.XLEN(64), .REGW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference condition evaluation: base test on cond[3:1], cond[0] inverts (except AL/NV)
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[0] && c[3:1] != 3'd7) r = !r;
    return r;
  endfunction

  function automatic logic model_taken();
    case (bus.ex_br_kind)
      2'd1: return 1'b1;
      2'd2: return bus.alu_zero ^ bus.ex_cbnz;
`ifdef EXMEM_NZCV_EN
      2'd3: return model_cond(bus.ex_cond, model_r.nzcv);
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic void push_expect();
    obs_t e;
    e = model_r;
    if (!bus.stall) begin
      if (bus.flush) begin
        e.p = '0;
      end else begin
        e.p.valid      = bus.ex_valid;
        e.p.result     = bus.alu_result;
        e.p.store_data = bus.ex_store_data;
        e.p.rd         = bus.ex_rd;
        e.p.mem_read   = bus.ex_mem_read;
        e.p.mem_write  = bus.ex_mem_write;
        e.p.reg_write  = bus.ex_reg_write;
        e.p.mem_to_reg = bus.ex_mem_to_reg;
        e.p.br_taken   = bus.ex_valid && model_taken();
        e.p.br_target  = bus.ex_br_target;
`ifdef EXMEM_NZCV_EN
        if (bus.ex_valid && bus.ex_set_flags && bus.ex_br_kind != 2'd3)
          e.nzcv = {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
`endif
      end
    end
    model_r = e;
    sb_q.push_back(e);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.p.valid      = bus.mem_valid;
    o.p.result     = bus.mem_result;
    o.p.store_data = bus.mem_store_data;
    o.p.rd         = bus.mem_rd;
    o.p.mem_read   = bus.mem_mem_read;
    o.p.mem_write  = bus.mem_mem_write;
    o.p.reg_write  = bus.mem_reg_write;
    o.p.mem_to_reg = bus.mem_mem_to_reg;
    o.p.br_taken   = bus.mem_br_taken;
    o.p.br_target  = bus.mem_br_target;
    o.nzcv         = bus.nzcv;
    return o;
  endfunction

  task automatic step();
    push_expect();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.ex_valid = 1'b0;     bus.alu_result = 64'd0;   bus.alu_zero = 1'b0;
    bus.alu_negative = 1'b0; bus.alu_carry = 1'b0;     bus.alu_overflow = 1'b0;
    bus.ex_set_flags = 1'b0; bus.ex_br_kind = 2'd0;    bus.ex_cbnz = 1'b0;
    bus.ex_cond = 4'd0;      bus.ex_br_target = 64'd0; bus.ex_store_data = 64'd0;
    bus.ex_rd = 5'd0;        bus.ex_mem_read = 1'b0;   bus.ex_mem_write = 1'b0;
    bus.ex_reg_write = 1'b0; bus.ex_mem_to_reg = 1'b0; bus.stall = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic set_alu(input logic [63:0] res, input logic n, input logic z,
                         input logic c, input logic v, input logic sf);
    bus.ex_valid = 1'b1;  bus.alu_result = res; bus.alu_negative = n;
    bus.alu_zero = z;     bus.alu_carry = c;    bus.alu_overflow = v;
    bus.ex_set_flags = sf;
  endtask

  task automatic set_br(input logic [1:0] kind, input logic cbnz,
                        input logic [3:0] cond, input logic [63:0] tgt);
    bus.ex_br_kind = kind; bus.ex_cbnz = cbnz; bus.ex_cond = cond; bus.ex_br_target = tgt;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    set_idle();
    rst_n = 1'b0;
    set_alu(64'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    bus.ex_rd = 5'd7; bus.ex_reg_write = 1'b1;
    #3;
    got = sample(); exp = '0; checks++;
    if (got !== exp) begin fails++; $display("FAIL reset_state got=%h exp=%h", got, exp); end
    model_r = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    exp = sb_q.pop_front(); got = sample(); checks++;
    if (got !== exp) begin fails++; $display("FAIL reset_first_edge got=%h exp=%h", got, exp); end
    // asynchronous reset arriving mid-cycle with live contents
    #2;
    rst_n = 1'b0;
    #1;
    got = sample(); exp = '0; checks++;
    if (got !== exp) begin fails++; $display("FAIL reset_midstream got=%h exp=%h", got, exp); end
    model_r = '0;
    #2;
    rst_n = 1'b1;
    set_br(2'd1, 1'b0, 4'd0, 64'h80);
    step();
    exp = sb_q.pop_front(); got = sample(); checks++;
    if (got !== exp) begin fails++; $display("FAIL reset_release got=%h exp=%h", got, exp); end
  endtask

  task automatic test_flags_eq();
    obs_t got, exp;
    logic [3:0] want;
    set_idle();
    set_alu(64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    bus.ex_rd = 5'd3; bus.ex_reg_write = 1'b1;
    step();
    exp = sb_q.pop_front(); got = sample(); checks++;
    if (got !== exp) begin fails++; $display("FAIL subs_payload got=%h exp=%h", got, exp); end
`ifdef EXMEM_NZCV_EN
    want = 4'b0110;
`else
    want = 4'b0000;
`endif
    checks++;
    if (bus.nzcv !== want) begin fails++; $display("FAIL subs_nzcv got=%b exp=%b", bus.nzcv, want); end
    for (int i = 0; i < 3; i++) begin
      set_idle();
      set_alu(64'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      set_br(2'd3, 1'b0, (i == 0) ? 4'd0 : (i == 1) ? 4'd1 : 4'd0, 64'h100 + 64'(i));
      if (i == 2) set_br(2'd0, 1'b0, 4'd0, 64'h0);
      step();
      exp = sb_q.pop_front(); got = sample(); checks++;
      if (got !== exp) begin fails++; $display("FAIL bcond_eq_ne[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_overflow();
    obs_t got, exp;
    set_idle();
    set_alu(64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    exp = sb_q.pop_front(); got = sample(); checks++;
    if (got !== exp) begin fails++; $display("FAIL adds_ovf got=%h exp=%h", got, exp); end
    for (int c = 10; c < 16; c++) begin
      set_idle();
      set_alu(64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      set_br(2'd3, 1'b0, 4'(c), 64'h200);
      step();
      exp = sb_q.pop_front(); got = sample(); checks++;
      if (got !== exp) begin fails++; $display("FAIL bcond_cc%0d got=%h exp=%h", c, got, exp); end
    end
  endtask

  task automatic test_cbz();
    obs_t got, exp;
    logic [3:0] pat;
    for (int i = 0; i < 5; i++) begin
      pat = 4'(i);
      set_idle();
      set_alu(64'(i), 1'b0, pat[0], 1'b0, 1'b0, 1'b0);
      set_br((i == 4) ? 2'd0 : 2'd2, pat[1], 4'd0, 64'h40);
      bus.ex_store_data = 64'hDEAD_0000 + 64'(i);
      step();
      exp = sb_q.pop_front(); got = sample(); checks++;
      if (got !== exp) begin fails++; $display("FAIL cbz_cbnz[%0d] got=%h exp=%h", i, got, exp); end
    end
    set_idle();
    set_br(2'd1, 1'b0, 4'd0, 64'h300);
    step();
    exp = sb_q.pop_front(); got = sample(); checks++;
    if (got !== exp) begin fails++; $display("FAIL b_invalid got=%h exp=%h", got, exp); end
  endtask

  task automatic test_stall_flush();
    obs_t got, exp;
    set_idle();
    set_alu(64'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    set_br(2'd1, 1'b0, 4'd0, 64'h500);
    bus.ex_mem_write = 1'b1; bus.ex_store_data = 64'hABCD;
    step();
    exp = sb_q.pop_front(); got = sample(); checks++;
    if (got !== exp) begin fails++; $display("FAIL pre_stall got=%h exp=%h", got, exp); end
    for (int i = 0; i < 4; i++) begin
      set_idle();
      bus.stall = 1'b1;
      bus.flush = (i == 3);
      set_alu(64'h77 + 64'(i), 1'b1, 1'b1, 1'b0, 1'b1, (i == 1));
      set_br(2'd2, 1'b1, 4'd0, 64'h600);
      bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd31;
      step();
      exp = sb_q.pop_front(); got = sample(); checks++;
      if (got !== exp) begin fails++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, got, exp); end
    end
    bus.stall = 1'b0;
    bus.flush = 1'b1;
    step();
    exp = sb_q.pop_front(); got = sample(); checks++;
    if (got !== exp) begin fails++; $display("FAIL flush_bubble got=%h exp=%h", got, exp); end
    bus.flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    obs_t got, exp;
    for (int i = 0; i < 40; i++) begin
      set_idle();
      set_alu({$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom));
      bus.ex_valid = ($urandom_range(0, 3) != 0);
      set_br(2'($urandom), 1'($urandom), 4'($urandom), {$urandom, $urandom});
      bus.ex_store_data = {$urandom, $urandom};
      bus.ex_rd = 5'($urandom);
      {bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write, bus.ex_mem_to_reg} = 4'($urandom);
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 5) == 0);
      step();
      exp = sb_q.pop_front(); got = sample(); checks++;
      if (got !== exp) begin fails++; $display("FAIL b2b[%0d] got=%h exp=%h", i, got, exp); end
    end
    set_idle();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    model_r = '0;
    test_reset();
    test_flags_eq();
    test_overflow();
    test_cbz();
    test_stall_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
